gate_bist: RTL and testbench
============================

Name: gate_bist

Overview:
Built-in self-test sequencer for the basic_gates block. It drives A/B through all four input combinations and waits a settle time after each one. It then captures the eight gate outputs, compares them against a built-in truth table, and reports a pass/fail summary. It sits directly upstream of basic_gates, feeding its inputs, and also consumes its outputs. It replaces a manual truth-table printout with a synthesizable checker.

Parameters:
SETTLE_CYCLES, 2, cycles to hold each A/B vector before sampling gate_out; legal range 1..15.
CNT_W, 4, width of the internal settle counter; must hold SETTLE_CYCLES.

Ports:
clk  input  1  single system clock, rising edge.
rst_n  input  1  reset, asynchronous and active-low.
start  input  1  single-cycle request to run the test; honoured only in IDLE or DONE.
gate_out  input  8  DUT outputs, bit0..7 = AND, OR, NOT_A, NOT_B, NAND, NOR, XOR, XNOR.
a  output  1  registered A drive to the DUT.
b  output  1  registered B drive to the DUT.
busy  output  1  high in SETTLE or CHECK.
done  output  1  high while in DONE (level, not pulse).
pass  output  1  done && err_count==0.
err_count  output  3  number of failing vectors, 0..4.
fail_vec  output  4  bit i set if vector i ({a,b}=i) mismatched.
first_fail_bits  output  8  XOR of expected vs captured gate_out for the first failing vector; 0 if none.

Behaviour:
- Reset (async assert, sync release): state=IDLE, a=0, b=0, busy=0, done=0, err_count=0, fail_vec=0, first_fail_bits=0.
- Vector order is idx 0..3 with {a,b}=idx: 00, 01, 10, 11.
- Expected gate_out values: idx0=8'hBC, idx1=8'h56, idx2=8'h5A, idx3=8'h83.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE/DONE with start=1: go to SETTLE. Set idx=0, {a,b}=00, cnt=0. Clear err_count, fail_vec and first_fail_bits. done drops the same edge.
- SETTLE: cnt increments each cycle. When cnt==SETTLE_CYCLES-1, go to CHECK.
- CHECK: sample gate_out and compare to expected(idx).
  - On mismatch: err_count+1 and fail_vec[idx]=1. If first_fail_bits==0, load the mismatch mask.
  - If idx==3, go to DONE. Otherwise idx+1, {a,b}=idx+1, cnt=0, go to SETTLE.
- Timing: with start sampled at edge t0, each vector costs SETTLE_CYCLES+1 cycles. done rises at t0+4*(SETTLE_CYCLES+1)+1, which is 13 for the default.
- a/b stay at 11 in DONE and return to 00 only on restart or reset.
- start during SETTLE/CHECK is ignored; no restart and no queuing.
- Reset mid-run: immediate return to IDLE with all outputs at reset values. No partial results are retained.
- X/Z on gate_out during CHECK counts as a mismatch in simulation. RTL uses a case-inequality equivalent in the model only; synthesis sees plain compare.
- err_count saturates naturally at 4; no overflow is possible.

Decomposition:
- Package gates_pkg holds:
  - gate bit-index constants (GATE_AND=0 ... GATE_XNOR=7);
  - the FSM state enum;
  - the expected-vector constants EXP_00/01/10/11.
- One sub-module, gate_ref_model: combinational, inputs a and b, output 8-bit expected vector. The BIST instantiates it on its registered a/b. It can be reused as a scoreboard model in benches.

Test Plan:
- gate_bist wired to a correct basic_gates, pulse start at cycle 0 -> done=1 at cycle 13, pass=1, err_count=0, fail_vec=0000, first_fail_bits=00.
- XOR output (gate_out[6]) stuck at 0, start -> err_count=2, fail_vec=0110, first_fail_bits=8'h40, pass=0.
- start re-pulsed at cycle 5 mid-run -> ignored, done still at cycle 13 with identical results. After done, a fresh start clears results and done drops on the next edge.
- rst_n asserted at cycle 7 mid-run -> a=b=0, busy=0, done=0, all results 0 immediately (asynchronous). A start after release runs to pass=1.
- SETTLE_CYCLES=4 with a correct DUT -> a/b hold each vector for 4 cycles, done at cycle 21, pass=1.
- NAND output (gate_out[4]) inverted -> err_count=4, fail_vec=1111, first_fail_bits=8'h10.

Source files
------------

// File: rtl/gates_pkg.sv
// gates_pkg: shared definitions for the basic_gates self-test.
//   - bit positions of each gate output within the 8-bit gate_out bus
//   - BIST sequencer state encoding
//   - golden gate_out vector for each {a,b} input combination
package gates_pkg;

  localparam int GATE_AND   = 0;
  localparam int GATE_OR    = 1;
  localparam int GATE_NOT_A = 2;
  localparam int GATE_NOT_B = 3;
  localparam int GATE_NAND  = 4;
  localparam int GATE_NOR   = 5;
  localparam int GATE_XOR   = 6;
  localparam int GATE_XNOR  = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } bist_state_e;

  // Golden gate_out for {a,b} = 00, 01, 10, 11.
  localparam logic [7:0] EXP_00 = 8'hBC;
  localparam logic [7:0] EXP_01 = 8'h56;
  localparam logic [7:0] EXP_10 = 8'h5A;
  localparam logic [7:0] EXP_11 = 8'h83;

endpackage

// File: rtl/gate_bist_if.sv
// gate_bist_if: bundle between the BIST sequencer and its environment.
//   start            request to run the self-test (single-cycle pulse)
//   gate_out         captured basic_gates outputs
//   a, b             stimulus driven into basic_gates
//   busy, done, pass run status
//   err_count        number of failing vectors (0..4)
//   fail_vec         per-vector failure flags, bit i = vector {a,b}=i
//   first_fail_bits  expected^captured mask of the first failing vector
// modport slave is the BIST side; modport master is the side that
// requests the test and supplies gate_out.
interface gate_bist_if;
  logic       start;
  logic [7:0] gate_out;
  logic       a;
  logic       b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [3:0] fail_vec;
  logic [7:0] first_fail_bits;

  modport slave (
    input  start, gate_out,
    output a, b, busy, done, pass, err_count, fail_vec, first_fail_bits
  );

  modport master (
    output start, gate_out,
    input  a, b, busy, done, pass, err_count, fail_vec, first_fail_bits
  );
endinterface

// File: rtl/gate_ref_model.sv
// gate_ref_model: combinational golden model of basic_gates.
//   a_i, b_i   gate inputs
//   exp_o      expected 8-bit gate_out for those inputs
module gate_ref_model
  import gates_pkg::*;
(
  input  logic       a_i,
  input  logic       b_i,
  output logic [7:0] exp_o
);

  always_comb begin
    exp_o = EXP_00;
    unique case ({a_i, b_i})
      2'b00:   exp_o = EXP_00;
      2'b01:   exp_o = EXP_01;
      2'b10:   exp_o = EXP_10;
      default: exp_o = EXP_11;
    endcase
  end

endmodule

// File: rtl/gate_bist.sv
// gate_bist: self-test sequencer for basic_gates.
// Walks {a,b} through 00,01,10,11, holds each for SETTLE_CYCLES cycles,
// then samples gate_out against the golden model and accumulates results.
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   bus      gate_bist_if.slave (start, gate_out in; a, b, status out)
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   ST_IDLE   | waiting for start, no results yet
//   ST_SETTLE | holding current {a,b} for SETTLE_CYCLES cycles
//   ST_CHECK  | sampling gate_out and scoring current vector
//   ST_DONE   | results valid, a/b parked at 11, restartable
module gate_bist
  import gates_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  gate_bist_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  bist_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             a_q;
  logic             b_q;
  logic             busy_q;
  logic             done_q;
  logic [2:0]       err_q;
  logic [3:0]       fail_q;
  logic [7:0]       ffb_q;

  logic [1:0]       idx;
  logic [1:0]       idx_nxt;
  logic [7:0]       exp_vec;
  logic [7:0]       miss_mask;
  logic             miss;

  // The vector index is the registered stimulus itself.
  assign idx     = {a_q, b_q};
  assign idx_nxt = idx + 2'd1;

  gate_ref_model u_ref (
    .a_i   (a_q),
    .b_i   (b_q),
    .exp_o (exp_vec)
  );

  // Case-inequality so X/Z on gate_out scores as a failure in simulation;
  // synthesis reduces it to an ordinary compare.
  assign miss_mask = bus.gate_out ^ exp_vec;
  assign miss      = (bus.gate_out !== exp_vec);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= '0;
      fail_q  <= '0;
      ffb_q   <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state_q <= ST_SETTLE;
            cnt_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= '0;
            fail_q  <= '0;
            ffb_q   <= '0;
          end
        end
        ST_SETTLE: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_q <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (miss) begin
            err_q       <= err_q + 3'd1;
            fail_q[idx] <= 1'b1;
            if (ffb_q == 8'h00) begin
              ffb_q <= miss_mask;
            end
          end
          if (idx == 2'd3) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_SETTLE;
            cnt_q   <= '0;
            a_q     <= idx_nxt[1];
            b_q     <= idx_nxt[0];
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.a               = a_q;
  assign bus.b               = b_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.pass            = done_q && (err_q == 3'd0);
  assign bus.err_count       = err_q;
  assign bus.fail_vec        = fail_q;
  assign bus.first_fail_bits = ffb_q;

endmodule

// File: tb/tb_gate_bist.sv
module tb_gate_bist;

  logic clk;
  logic rst_n;
  int   fault;     // 0 = good DUT, 1 = XOR stuck 0, 2 = NAND inverted
  int   n_chk;
  int   n_fail;
  int   lat;

  gate_bist_if bus0 ();
  gate_bist_if bus1 ();

  gate_bist u0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  gate_bist #(.SETTLE_CYCLES(4), .CNT_W(4)) u1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural basic_gates with optional planted faults.
  always_comb begin
    logic [7:0] g;
    logic       a;
    logic       b;
    a = bus0.a;
    b = bus0.b;
    g = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~b, ~a, a | b, a & b};
    if (fault == 1)      g[6] = 1'b0;
    else if (fault == 2) g[4] = ~g[4];
    bus0.gate_out = g;
  end

  always_comb begin
    logic a;
    logic b;
    a = bus1.a;
    b = bus1.b;
    bus1.gate_out = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~b, ~a, a | b, a & b};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start in cycle 0 (sampled at edge 1), then count edges until done.
  // Checks a/b, busy and done every cycle against the vector schedule.
  task automatic run(input int sel, input int repulse_at, input int exp_lat, output int n);
    int per;
    int exp_ab;
    logic d;
    per = sel ? 5 : 3;
    @(posedge clk); #1;
    if (sel) bus1.start = 1'b1; else bus0.start = 1'b1;
    n = 0;
    d = 1'b0;
    while (!d && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (sel) bus1.start = (n == repulse_at); else bus0.start = (n == repulse_at);
      d = sel ? bus1.done : bus0.done;
      exp_ab = (n - 1) / per;
      if (exp_ab > 3) exp_ab = 3;
      if (n <= exp_lat) begin
        chk("ab", sel ? {bus1.a, bus1.b} : {bus0.a, bus0.b}, exp_ab);
        chk("busy", sel ? bus1.busy : bus0.busy, (n < exp_lat));
      end
      if (n == 1 && !sel) begin
        chk("restart_done", bus0.done, 0);
        chk("restart_err", bus0.err_count, 0);
        chk("restart_fv", bus0.fail_vec, 0);
        chk("restart_ffb", bus0.first_fail_bits, 0);
      end
    end
    if (!d) chk("timeout", 0, 1);
    if (sel) bus1.start = 1'b0; else bus0.start = 1'b0;
  endtask

  task automatic check_res(input string tag, input logic [2:0] e_err, input logic [3:0] e_fv,
                           input logic [7:0] e_ffb, input logic e_pass);
    chk({tag, "_err"}, bus0.err_count, e_err);
    chk({tag, "_fv"}, bus0.fail_vec, e_fv);
    chk({tag, "_ffb"}, bus0.first_fail_bits, e_ffb);
    chk({tag, "_pass"}, bus0.pass, e_pass);
    chk({tag, "_done"}, bus0.done, 1);
  endtask

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    fault      = 0;
    rst_n      = 1'b0;
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ab", {bus0.a, bus0.b}, 0);
    chk("rst_status", {bus0.busy, bus0.done, bus0.pass}, 0);
    chk("rst_res", {bus0.err_count, bus0.fail_vec, bus0.first_fail_bits}, 0);
    chk("rst_u1", {bus1.busy, bus1.done, bus1.err_count}, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_busy", bus0.busy, 0);

    // Good DUT
    run(0, -1, 13, lat);
    chk("good_lat", lat, 13);
    check_res("good", 3'd0, 4'h0, 8'h00, 1'b1);

    // XOR stuck at 0
    fault = 1;
    run(0, -1, 13, lat);
    chk("xor_lat", lat, 13);
    check_res("xor", 3'd2, 4'h6, 8'h40, 1'b0);

    // Good DUT, restart from DONE, extra start at cycle 5 must be ignored
    fault = 0;
    run(0, 5, 13, lat);
    chk("repulse_lat", lat, 13);
    check_res("repulse", 3'd0, 4'h0, 8'h00, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("done_level", bus0.done, 1);
    chk("done_ab", {bus0.a, bus0.b}, 3);

    // Reset mid-run after one failure has been recorded
    fault = 1;
    @(posedge clk); #1;
    bus0.start = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      @(posedge clk); #1;
      bus0.start = 1'b0;
    end
    chk("pre_rst_err", bus0.err_count, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_ab", {bus0.a, bus0.b}, 0);
    chk("arst_busy", bus0.busy, 0);
    chk("arst_done", bus0.done, 0);
    chk("arst_res", {bus0.err_count, bus0.fail_vec, bus0.first_fail_bits}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    fault = 0;
    run(0, -1, 13, lat);
    chk("post_rst_lat", lat, 13);
    check_res("post_rst", 3'd0, 4'h0, 8'h00, 1'b1);

    // NAND inverted: every vector fails
    fault = 2;
    run(0, -1, 13, lat);
    chk("nand_lat", lat, 13);
    check_res("nand", 3'd4, 4'hF, 8'h10, 1'b0);
    fault = 0;

    // SETTLE_CYCLES = 4 instance
    run(1, -1, 21, lat);
    chk("s4_lat", lat, 21);
    chk("s4_pass", bus1.pass, 1);
    chk("s4_err", bus1.err_count, 0);
    chk("s4_fv", bus1.fail_vec, 0);

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
